// File: rtl/fb_access_arbiter.sv
// Single-port framebuffer arbiter: scan-out reads always win, queued pixel writes and
// the clear sequencer fill whatever RAM cycles the display leaves free.
module fb_access_arbiter #(
  parameter int          FB_W        = 200,
  parameter int          FB_H        = 150,
  parameter int          SCALE_SHIFT = 2,
  parameter int          ADDR_W      = 15,
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [11:0] CLEAR_COLOR = 12'h000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              disp_active,
  input  logic [9:0]        disp_x,
  input  logic [9:0]        disp_y,
  output logic [3:0]        pix_r,
  output logic [3:0]        pix_g,
  output logic [3:0]        pix_b,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [9:0]        wr_x,
  input  logic [9:0]        wr_y,
  input  logic [11:0]       wr_color,
  output logic              wr_drop,
  input  logic              clear_req,
  output logic              clear_busy,
  output logic              clear_done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [11:0]       ram_wdata,
  input  logic [11:0]       ram_rdata
);

  localparam int                PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [9:0]        FB_W_C   = 10'(FB_W);
  localparam logic [9:0]        FB_H_C   = 10'(FB_H);
  localparam logic [ADDR_W-1:0] FB_W_A   = ADDR_W'(FB_W);
  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(FB_W * FB_H - 1);
  localparam logic [PTR_W:0]    FIFO_FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_CLEAR
  } state_t;

  state_t state_reg, state_next;

  logic [9:0]        fb_dx, fb_dy;
  logic              disp_vis;
  logic [ADDR_W-1:0] disp_addr;
  logic              rd_slot;
  logic              free_slot;
  logic              last_valid_reg;
  logic [ADDR_W-1:0] last_addr_reg;

  logic              s1_vis_reg, s1_fresh_reg;
  logic [11:0]       pix_reg;

  logic              wr_fire, wr_in_range, fifo_push, fifo_pop, fifo_empty;
  logic [ADDR_W-1:0] wr_addr_calc;
  logic [PTR_W-1:0]  wptr_reg, rptr_reg;
  logic [PTR_W:0]    fifo_count_reg;
  logic [ADDR_W-1:0] fifo_addr_mem [FIFO_DEPTH];
  logic [11:0]       fifo_data_mem [FIFO_DEPTH];
  logic              wr_drop_reg;

  logic              clr_wr;
  logic [ADDR_W-1:0] clr_cnt_reg, clr_cnt_next;
  logic              clear_done_reg, clear_done_next;

  // Display side: replicated screen coordinate folds onto the low-res buffer.
  assign fb_dx     = disp_x >> SCALE_SHIFT;
  assign fb_dy     = disp_y >> SCALE_SHIFT;
  assign disp_vis  = disp_active && (fb_dx < FB_W_C) && (fb_dy < FB_H_C);
  assign disp_addr = ADDR_W'(fb_dy) * FB_W_A + ADDR_W'(fb_dx);
  assign rd_slot   = disp_vis && !(last_valid_reg && (disp_addr == last_addr_reg));
  assign free_slot = !rd_slot;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_valid_reg <= 1'b0;
      last_addr_reg  <= '0;
    end else if (rd_slot) begin
      last_valid_reg <= 1'b1;
      last_addr_reg  <= disp_addr;
    end else if (!disp_vis) begin
      last_valid_reg <= 1'b0;
    end
  end

  // Repeated addresses skip the RAM, so stage 2 holds the colour it already has.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_vis_reg   <= 1'b0;
      s1_fresh_reg <= 1'b0;
      pix_reg      <= '0;
    end else begin
      s1_vis_reg   <= disp_vis;
      s1_fresh_reg <= rd_slot;
      if (!s1_vis_reg) begin
        pix_reg <= '0;
      end else if (s1_fresh_reg) begin
        pix_reg <= ram_rdata;
      end
    end
  end

  assign pix_r = pix_reg[11:8];
  assign pix_g = pix_reg[7:4];
  assign pix_b = pix_reg[3:0];

  // Write queue
  assign fifo_empty   = (fifo_count_reg == '0);
  assign wr_ready     = (fifo_count_reg != FIFO_FULL_CNT) && (state_reg == ST_IDLE);
  assign wr_fire      = wr_valid && wr_ready;
  assign wr_in_range  = (wr_x < FB_W_C) && (wr_y < FB_H_C);
  assign wr_addr_calc = ADDR_W'(wr_y) * FB_W_A + ADDR_W'(wr_x);
  assign fifo_push    = wr_fire && wr_in_range;
  assign clr_wr       = free_slot && (state_reg == ST_CLEAR);
  assign fifo_pop     = free_slot && (state_reg != ST_CLEAR) && !fifo_empty;

  generate
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_fifo_entry
      always_ff @(posedge clk) begin
        if (fifo_push && (wptr_reg == PTR_W'(gi))) begin
          fifo_addr_mem[gi] <= wr_addr_calc;
          fifo_data_mem[gi] <= wr_color;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_reg       <= '0;
      rptr_reg       <= '0;
      fifo_count_reg <= '0;
      wr_drop_reg    <= 1'b0;
    end else begin
      wr_drop_reg <= wr_fire && !wr_in_range;
      if (fifo_push) begin
        wptr_reg <= wptr_reg + PTR_W'(1);
      end
      if (fifo_pop) begin
        rptr_reg <= rptr_reg + PTR_W'(1);
      end
      case ({fifo_push, fifo_pop})
        2'b10:   fifo_count_reg <= fifo_count_reg + 1'b1;
        2'b01:   fifo_count_reg <= fifo_count_reg - 1'b1;
        default: fifo_count_reg <= fifo_count_reg;
      endcase
    end
  end

  assign wr_drop = wr_drop_reg;

  // RAM port mux: display read, else clear, else queue head.
  always_comb begin
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    if (rd_slot) begin
      ram_addr = disp_addr;
    end else if (clr_wr) begin
      ram_we    = 1'b1;
      ram_addr  = clr_cnt_reg;
      ram_wdata = CLEAR_COLOR;
    end else if (fifo_pop) begin
      ram_we    = 1'b1;
      ram_addr  = fifo_addr_mem[rptr_reg];
      ram_wdata = fifo_data_mem[rptr_reg];
    end
  end

  // Clear sequencer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= ST_IDLE;
      clr_cnt_reg    <= '0;
      clear_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      clr_cnt_reg    <= clr_cnt_next;
      clear_done_reg <= clear_done_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    clr_cnt_next    = clr_cnt_reg;
    clear_done_next = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (clear_req) begin
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        clr_cnt_next = '0;
        if (fifo_empty) begin
          state_next = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        if (clr_wr) begin
          clr_cnt_next = clr_cnt_reg + 1'b1;
          if (clr_cnt_reg == CLR_LAST) begin
            state_next      = ST_IDLE;
            clear_done_next = 1'b1;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign clear_busy = (state_reg != ST_IDLE);
  assign clear_done = clear_done_reg;

endmodule
